// File: rtl/inference_sequencer_if.sv
// Bundle of every non-clock signal of the inference sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface inference_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int IDX_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tlast;
    logic                    s_axis_tready;

    logic                    pkt_valid;
    logic [IDX_WIDTH-1:0]    pkt_idx;
    logic [DATA_WIDTH-1:0]   pkt_data;
    logic                    core_abort;
    logic                    core_finish;
    logic [DATA_WIDTH-1:0]   core_result;

    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic                    m_axis_tready;

    logic                    err_clr;
    logic                    err_early_last;
    logic                    err_no_last;
    logic                    err_spurious;
    logic                    err_timeout;
    logic [31:0]             image_count;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output pkt_valid, pkt_idx, pkt_data, core_abort,
        input  core_finish, core_result,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        input  err_clr,
        output err_early_last, err_no_last, err_spurious, err_timeout,
        output image_count
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  pkt_valid, pkt_idx, pkt_data, core_abort,
        output core_finish, core_result,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        output err_clr,
        input  err_early_last, err_no_last, err_spurious, err_timeout,
        input  image_count
    );
endinterface

// File: rtl/inference_sequencer.sv
// Inference sequencer: streams one image of PACKETS_NUM beats into the
// inference core, waits (bounded) for its result and emits it as a single
// AXI-Stream beat. Framing errors, spurious finishes and timeouts are
// reported through sticky flags.
module inference_sequencer #(
    parameter int PACKETS_NUM        = 13,
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    inference_sequencer_if.slave  bus
);
    localparam int IDX_W  = (PACKETS_NUM > 1) ? $clog2(PACKETS_NUM) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(PACKETS_NUM - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE      = IDX_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE     = WAIT_W'(1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  beat_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ready_en;

    logic beat_accept;
    logic early_last;
    logic no_last;
    logic timeout_hit;
    logic spurious;
    logic out_handshake;

    // Upstream is only accepted in LOAD and never before the first edge after reset.
    assign bus.s_axis_tready = ready_en && (state == ST_LOAD);
    assign beat_accept       = bus.s_axis_tvalid && bus.s_axis_tready;
    assign early_last        = beat_accept && bus.s_axis_tlast && (beat_cnt != LAST_IDX);
    assign no_last           = beat_accept && !bus.s_axis_tlast && (beat_cnt == LAST_IDX);
    assign timeout_hit       = (state == ST_WAIT) && !bus.core_finish && (wait_cnt == WAIT_LAST);
    assign spurious          = bus.core_finish && (state != ST_WAIT);
    assign out_handshake     = (state == ST_SEND) && bus.m_axis_tready;

    // Output stream qualifiers derive straight from the state so reset clears them at once.
    assign bus.m_axis_tvalid = (state == ST_SEND);
    assign bus.m_axis_tlast  = (state == ST_SEND);
    assign bus.m_axis_tkeep  = (state == ST_SEND) ? '1 : '0;

    // Opens the upstream ready on the first clock edge after reset release.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Main sequencing FSM with beat forwarding, result capture and image counting.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state            <= ST_LOAD;
            beat_cnt         <= '0;
            wait_cnt         <= '0;
            bus.pkt_valid    <= 1'b0;
            bus.pkt_idx      <= '0;
            bus.pkt_data     <= '0;
            bus.core_abort   <= 1'b0;
            bus.m_axis_tdata <= '0;
            bus.image_count  <= '0;
        end else begin
            bus.pkt_valid  <= 1'b0;
            bus.core_abort <= 1'b0;
            case (state)
                ST_LOAD: begin
                    wait_cnt <= '0;
                    if (beat_accept) begin
                        if (early_last) begin
                            bus.core_abort <= 1'b1;
                            beat_cnt       <= '0;
                        end else begin
                            bus.pkt_valid <= 1'b1;
                            bus.pkt_idx   <= beat_cnt;
                            bus.pkt_data  <= bus.s_axis_tdata;
                            if (beat_cnt == LAST_IDX) begin
                                beat_cnt <= '0;
                                state    <= ST_WAIT;
                            end else begin
                                beat_cnt <= beat_cnt + IDX_ONE;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    beat_cnt <= '0;
                    if (bus.core_finish) begin
                        bus.m_axis_tdata <= bus.core_result;
                        wait_cnt         <= '0;
                        state            <= ST_SEND;
                    end else if (timeout_hit) begin
                        bus.core_abort <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= ST_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                ST_SEND: begin
                    beat_cnt <= '0;
                    wait_cnt <= '0;
                    if (out_handshake) begin
                        bus.image_count <= bus.image_count + 32'd1;
                        state           <= ST_LOAD;
                    end
                end
                default: begin
                    beat_cnt <= '0;
                    wait_cnt <= '0;
                    state    <= ST_LOAD;
                end
            endcase
        end
    end

    // Sticky error flags; a new error event in the same cycle beats err_clr.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            bus.err_early_last <= 1'b0;
            bus.err_no_last    <= 1'b0;
            bus.err_spurious   <= 1'b0;
            bus.err_timeout    <= 1'b0;
        end else begin
            bus.err_early_last <= early_last  ? 1'b1 : (bus.err_clr ? 1'b0 : bus.err_early_last);
            bus.err_no_last    <= no_last     ? 1'b1 : (bus.err_clr ? 1'b0 : bus.err_no_last);
            bus.err_spurious   <= spurious    ? 1'b1 : (bus.err_clr ? 1'b0 : bus.err_spurious);
            bus.err_timeout    <= timeout_hit ? 1'b1 : (bus.err_clr ? 1'b0 : bus.err_timeout);
        end
    end
endmodule

// File: tb/tb_inference_sequencer.sv
// Directed self-checking bench for inference_sequencer.
module tb_inference_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    inference_sequencer_if #(.DATA_WIDTH(64), .IDX_WIDTH(4)) bus ();

    inference_sequencer #(
        .PACKETS_NUM(13),
        .C_AXIS_TDATA_WIDTH(64),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one upstream beat for exactly one clock edge.
    task automatic applyStimulus(input logic [63:0] data, input logic last);
        bus.s_axis_tdata  = data;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = last;
        tick();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // Sends beats 0..count-1 and checks each is forwarded one cycle later.
    task automatic loadBeats(input int count, input logic [63:0] base, input logic last_on_final);
        for (int i = 0; i < count; i++) begin
            applyStimulus(base + 64'(i), last_on_final && (i == count - 1));
            checkOutput("pkt_valid", 64'(bus.pkt_valid), 64'd1);
            checkOutput("pkt_idx", 64'(bus.pkt_idx), 64'(i));
            checkOutput("pkt_data", bus.pkt_data, base + 64'(i));
        end
    endtask

    task automatic finishCore(input logic [63:0] result);
        bus.core_result = result;
        bus.core_finish = 1'b1;
        tick();
        bus.core_finish = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.core_finish   = 1'b0;
        bus.core_result   = '0;
        bus.m_axis_tready = 1'b1;
        bus.err_clr       = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        checkOutput("rst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
        checkOutput("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        checkOutput("rst_m_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
        checkOutput("rst_image_count", 64'(bus.image_count), 64'd0);
        checkOutput("rst_errors", 64'({bus.err_early_last, bus.err_no_last, bus.err_spurious, bus.err_timeout}), 64'd0);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("tready_before_edge", 64'(bus.s_axis_tready), 64'd0);
        tick();
        checkOutput("tready_after_edge", 64'(bus.s_axis_tready), 64'd1);

        // Nominal image, result 0x5 twenty cycles after the last beat
        $display("[TB] nominal image");
        loadBeats(13, 64'h100, 1'b1);
        checkOutput("wait_tready", 64'(bus.s_axis_tready), 64'd0);
        tick();
        checkOutput("pkt_valid_idle", 64'(bus.pkt_valid), 64'd0);
        repeat (18) tick();
        checkOutput("wait_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        finishCore(64'h5);
        checkOutput("send_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        checkOutput("send_tlast", 64'(bus.m_axis_tlast), 64'd1);
        checkOutput("send_tkeep", 64'(bus.m_axis_tkeep), 64'hFF);
        checkOutput("send_tdata", bus.m_axis_tdata, 64'h5);
        checkOutput("send_s_tready", 64'(bus.s_axis_tready), 64'd0);
        tick();
        checkOutput("post_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        checkOutput("post_tlast", 64'(bus.m_axis_tlast), 64'd0);
        checkOutput("post_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
        checkOutput("image_count_1", 64'(bus.image_count), 64'd1);
        checkOutput("zero_bubble_tready", 64'(bus.s_axis_tready), 64'd1);
        checkOutput("no_errors", 64'({bus.err_early_last, bus.err_no_last, bus.err_spurious, bus.err_timeout}), 64'd0);

        // Early tlast on beat 5, then a clean image
        $display("[TB] early tlast");
        loadBeats(5, 64'h200, 1'b0);
        applyStimulus(64'h205, 1'b1);
        checkOutput("early_not_forwarded", 64'(bus.pkt_valid), 64'd0);
        checkOutput("early_abort", 64'(bus.core_abort), 64'd1);
        checkOutput("early_err", 64'(bus.err_early_last), 64'd1);
        checkOutput("early_still_load", 64'(bus.s_axis_tready), 64'd1);
        tick();
        checkOutput("abort_one_cycle", 64'(bus.core_abort), 64'd0);
        loadBeats(13, 64'h300, 1'b1);
        finishCore(64'hA5A5);
        checkOutput("send_tdata_2", bus.m_axis_tdata, 64'hA5A5);
        tick();
        checkOutput("image_count_2", 64'(bus.image_count), 64'd2);
        checkOutput("no_last_clean", 64'(bus.err_no_last), 64'd0);

        // Backpressure in SEND for 10 cycles
        $display("[TB] backpressure");
        bus.m_axis_tready = 1'b0;
        loadBeats(13, 64'h400, 1'b1);
        finishCore(64'hDEADBEEF_12345678);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
            checkOutput("bp_tdata", bus.m_axis_tdata, 64'hDEADBEEF_12345678);
            checkOutput("bp_s_tready", 64'(bus.s_axis_tready), 64'd0);
            tick();
        end
        checkOutput("bp_count_held", 64'(bus.image_count), 64'd2);
        bus.m_axis_tready = 1'b1;
        tick();
        checkOutput("image_count_3", 64'(bus.image_count), 64'd3);
        checkOutput("bp_release_tvalid", 64'(bus.m_axis_tvalid), 64'd0);

        // err_clr, and a spurious finish racing err_clr
        $display("[TB] error clear");
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checkOutput("clr_early", 64'(bus.err_early_last), 64'd0);
        bus.err_clr     = 1'b1;
        bus.core_finish = 1'b1;
        tick();
        bus.err_clr     = 1'b0;
        bus.core_finish = 1'b0;
        checkOutput("spurious_wins", 64'(bus.err_spurious), 64'd1);
        checkOutput("spurious_ignored", 64'(bus.m_axis_tvalid), 64'd0);
        checkOutput("spurious_still_load", 64'(bus.s_axis_tready), 64'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checkOutput("clr_spurious", 64'(bus.err_spurious), 64'd0);

        // Missing tlast, then no finish -> timeout after 4096 WAIT cycles
        $display("[TB] missing tlast and timeout");
        loadBeats(13, 64'h500, 1'b0);
        checkOutput("no_last_err", 64'(bus.err_no_last), 64'd1);
        checkOutput("no_last_wait", 64'(bus.s_axis_tready), 64'd0);
        for (int i = 0; i < 4095; i++) tick();
        checkOutput("pre_timeout_wait", 64'(bus.s_axis_tready), 64'd0);
        checkOutput("pre_timeout_err", 64'(bus.err_timeout), 64'd0);
        checkOutput("pre_timeout_abort", 64'(bus.core_abort), 64'd0);
        tick();
        checkOutput("timeout_err", 64'(bus.err_timeout), 64'd1);
        checkOutput("timeout_abort", 64'(bus.core_abort), 64'd1);
        checkOutput("timeout_load", 64'(bus.s_axis_tready), 64'd1);
        checkOutput("timeout_count", 64'(bus.image_count), 64'd3);

        // Reset after beat 7 of an image
        $display("[TB] mid-image reset");
        loadBeats(8, 64'h600, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
        checkOutput("arst_abort", 64'(bus.core_abort), 64'd0);
        checkOutput("arst_m_tdata", bus.m_axis_tdata, 64'd0);
        checkOutput("arst_image_count", 64'(bus.image_count), 64'd0);
        checkOutput("arst_errors", 64'({bus.err_early_last, bus.err_no_last, bus.err_spurious, bus.err_timeout}), 64'd0);
        checkOutput("arst_tready", 64'(bus.s_axis_tready), 64'd0);
        tick();
        tick();
        checkOutput("arst_abort_held", 64'(bus.core_abort), 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("rerelease_tready", 64'(bus.s_axis_tready), 64'd1);
        loadBeats(2, 64'h700, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter PACKETS_NUM, default 13: input beats per image.
REQ-002 SHALL have parameter C_AXIS_TDATA_WIDTH, default 64: data width of all streams.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum WAIT duration.
REQ-004 SHALL have port s00_axis_aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port s00_axis_aresetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports s_axis_tdata/tvalid/tlast  in  W/1/1, and s_axis_tready  out  1: upstream image beats.
REQ-007 SHALL have ports pkt_valid  out  1, pkt_idx  out  clog2(PACKETS_NUM), and pkt_data  out  W: beat to inference core.
REQ-008 SHALL have port core_abort  out  1: one-cycle pulse telling the core to discard its partial image.
REQ-009 SHALL have ports core_finish  in  1 (pulse) and core_result  in  W: classification result.
REQ-010 SHALL have ports m_axis_tdata  out  W, m_axis_tkeep  out  W/8, m_axis_tvalid  out  1, m_axis_tlast  out  1, and m_axis_tready  in  1.
REQ-011 SHALL have port err_clr  in  1, and ports err_early_last, err_no_last, err_spurious, err_timeout  out  1 each: sticky status.
REQ-012 SHALL have port image_count  out  32: completed images.

Function
REQ-013 SHALL implement FSM states LOAD, WAIT, SEND; reset state LOAD.
REQ-014 LOAD: s_axis_tready SHALL be 1; each accepted beat (tvalid&tready) SHALL appear on pkt_data/pkt_idx with pkt_valid=1 exactly one cycle later; pkt_valid SHALL be 0 otherwise.
REQ-015 pkt_idx SHALL equal beat count within the image, 0..PACKETS_NUM-1; beat counter SHALL clear on leaving LOAD.
REQ-016 Accepting beat PACKETS_NUM-1 SHALL move to WAIT next cycle; s_axis_tready SHALL be 0 in WAIT and SEND.
REQ-017 tlast on a beat with index < PACKETS_NUM-1: beat SHALL NOT be forwarded, core_abort SHALL pulse next cycle, err_early_last SHALL set, counter SHALL clear, state SHALL remain LOAD.
REQ-018 tlast=0 on beat PACKETS_NUM-1: err_no_last SHALL set; image SHALL proceed normally.
REQ-019 WAIT: on core_finish, core_result SHALL be registered into m_axis_tdata and state SHALL move to SEND next cycle.
REQ-020 WAIT cycle counter SHALL abort when it reaches TIMEOUT_CYCLES without core_finish: err_timeout sets, core_abort pulses, state returns to LOAD.
REQ-021 core_finish in LOAD or SEND SHALL be ignored and SHALL set err_spurious.
REQ-022 SEND: m_axis_tvalid=1, m_axis_tlast=1, m_axis_tkeep all ones, and tdata SHALL stay stable until m_axis_tready.
REQ-023 On handshake in SEND: m_axis_tvalid, tkeep, and tlast SHALL drop next cycle, image_count SHALL increment (wraps at 2^32), and state SHALL return to LOAD.
REQ-024 Outside SEND, m_axis_tvalid, m_axis_tlast, and m_axis_tkeep SHALL be 0.
REQ-025 err_clr SHALL clear all sticky flags; a same-cycle set SHALL win over clear.
REQ-026 Handshake latency SHALL be zero-bubble: an image's first beat SHALL be accepted in the cycle after the SEND handshake.

Reset
REQ-027 Reset assertion SHALL immediately (asynchronously) force state LOAD, counters 0, image_count 0, all error flags 0, and pkt_valid, core_abort, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, and m_axis_tdata 0.
REQ-028 While reset is asserted, s_axis_tready SHALL be 0; it SHALL be 1 from the first clock edge after deassertion.
REQ-029 Reset mid-image SHALL discard partial state with no core_abort pulse; the core is reset by the same signal.

Verification
REQ-030 13 beats, tlast on beat 12, core_finish 20 cycles later with result 0x5, m_axis_tready=1 -> pkt_idx 0..12, one output beat tdata=0x5 with tlast=1 and tkeep=0xFF, image_count=1.
REQ-031 tlast on beat 5 -> 5 beats forwarded, core_abort pulse, err_early_last=1; next 13-beat image completes normally.
REQ-032 m_axis_tready held 0 for 10 cycles in SEND -> tdata stable, tvalid held, s_axis_tready=0 throughout.
REQ-033 No core_finish after 13 beats -> after 4096 WAIT cycles, err_timeout=1, core_abort pulse, back in LOAD.
REQ-034 Reset asserted after beat 7 -> outputs zero immediately; fresh image then starts at pkt_idx 0.
REQ-035 Assert err_clr in the same cycle as a spurious core_finish -> err_spurious=1.
